// File: rtl/prio_pkg.sv
// ---------------------------------------------------------------------------
// prio_pkg
// Shared types for the priority arbiter slice.
//   state_t : arbiter FSM states (IDLE, GRANT)
//   mode_t  : arbitration mode (FIXED = highest index wins, RR = round-robin)
// ---------------------------------------------------------------------------
package prio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } mode_t;

endpackage

// File: rtl/prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc
// Combinational priority encoder: reports the index of the highest set bit.
// Ports:
//   req [N-1:0]   : input vector
//   vld           : at least one bit of req is set
//   idx [IDW-1:0] : index of the highest set bit (0 when vld = 0)
// ---------------------------------------------------------------------------
module prio_enc #(
    parameter  int N   = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    output logic           vld,
    output logic [IDW-1:0] idx
);

    assign vld = |req;

    // Scanning upward lets the last (highest) set bit overwrite earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// ---------------------------------------------------------------------------
// prio_arbiter
// Two-state arbiter granting one of N requesters, either by fixed priority
// (highest index wins) or round-robin (downward search from a pointer).
// A grant is held until done or until MAX_HOLD cycles have elapsed.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req [N-1:0]     : request vector, bit i = requester i
//   mode            : 0 = FIXED, 1 = RR (sampled only when idle)
//   done            : granted requester releases the grant
//   gnt_vld         : grant active
//   gnt_id [IDW-1:0]: binary index of the granted requester
//   gnt_oh [N-1:0]  : one-hot grant, zero when no grant
//   timeout         : one-cycle pulse when a grant is forcibly released
// ---------------------------------------------------------------------------
module prio_arbiter
    import prio_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int MAX_HOLD = 16,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           mode,
    input  logic           done,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   gnt_oh,
    output logic           timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [HW-1:0]  hold;

    mode_t          arb_mode;
    logic           fix_vld;
    logic [IDW-1:0] fix_id;
    logic [IDW:0]   rot_sh;
    logic [N-1:0]   rot_req;
    logic           rr_vld;
    logic [IDW-1:0] rr_rot_id;
    logic [IDW:0]   rr_sum;
    logic [IDW-1:0] rr_id;
    logic           win_vld;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_oh;
    logic           hold_last;

    assign arb_mode = mode_t'(mode);

    prio_enc #(.N(N)) u_fix_enc (
        .req (req),
        .vld (fix_vld),
        .idx (fix_id)
    );

    // Rotate so that req[ptr] lands on bit N-1, req[ptr-1] on bit N-2, and so
    // on; the highest-bit encoder then performs the downward search from ptr.
    assign rot_sh  = {1'b0, ptr} + (IDW+1)'(1);
    assign rot_req = N'({req, req} >> rot_sh);

    prio_enc #(.N(N)) u_rr_enc (
        .req (rot_req),
        .vld (rr_vld),
        .idx (rr_rot_id)
    );

    // Undo the rotation: original index = (rotated index + ptr + 1) mod N.
    // The sum stays below 2N, so one conditional subtraction suffices.
    assign rr_sum = {1'b0, rr_rot_id} + rot_sh;
    assign rr_id  = (rr_sum >= (IDW+1)'(N)) ? IDW'(rr_sum - (IDW+1)'(N))
                                            : IDW'(rr_sum);

    assign win_vld   = (arb_mode == RR) ? rr_vld : fix_vld;
    assign win_id    = (arb_mode == RR) ? rr_id  : fix_id;
    assign win_oh    = N'(1) << win_id;
    assign hold_last = (hold == HW'(MAX_HOLD - 1));

    // Single FSM register block; every output is a flop so the grant is
    // glitch-free and appears one edge after arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_id  <= '0;
            gnt_oh  <= '0;
            timeout <= 1'b0;
            hold    <= '0;
            ptr     <= IDW'(N - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= GRANT;
                        gnt_vld <= 1'b1;
                        gnt_id  <= win_id;
                        gnt_oh  <= win_oh;
                        hold    <= '0;
                        if (arb_mode == RR) begin
                            ptr <= (win_id == '0) ? IDW'(N - 1)
                                                  : win_id - IDW'(1);
                        end
                    end
                end
                GRANT: begin
                    // done takes precedence over a coincident hold expiry.
                    if (done) begin
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                        gnt_oh  <= '0;
                    end else if (hold_last) begin
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                        gnt_oh  <= '0;
                        timeout <= 1'b1;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prio_arbiter
// Directed, table-driven bench for prio_arbiter (N = 16, MAX_HOLD = 4),
// plus hand-written sequences for asynchronous reset and idle periods.
// ---------------------------------------------------------------------------
module tb_prio_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           mode;
    logic           done;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   gnt_oh;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic           mode;
        logic           done;
        logic           vld;
        logic [IDW-1:0] id;
        logic           to;
    } vec_t;

    vec_t vecs[$];

    prio_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mode    (mode),
        .done    (done),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .gnt_oh  (gnt_oh),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic [N-1:0] r, input logic m, input logic d,
                          input logic v, input logic [IDW-1:0] i, input logic t);
        vec_t x;
        x.req  = r;
        x.mode = m;
        x.done = d;
        x.vld  = v;
        x.id   = i;
        x.to   = t;
        vecs.push_back(x);
    endtask

    // Inputs are driven 1 time unit after a rising edge and sampled by the
    // next edge; outputs are then read 1 time unit after that edge.
    task automatic applyStimulus(input logic [N-1:0] r, input logic m, input logic d);
        req  = r;
        mode = m;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic v,
                               input logic [IDW-1:0] i, input logic t);
        logic [N-1:0] eoh;
        eoh = v ? (N'(1) << i) : '0;
        checks++;
        if (gnt_vld !== v) begin
            errors++;
            $display("[TB] FAIL %s gnt_vld: got %b expected %b", name, gnt_vld, v);
        end
        checks++;
        if (gnt_oh !== eoh) begin
            errors++;
            $display("[TB] FAIL %s gnt_oh: got %h expected %h", name, gnt_oh, eoh);
        end
        checks++;
        if (timeout !== t) begin
            errors++;
            $display("[TB] FAIL %s timeout: got %b expected %b", name, timeout, t);
        end
        if (v) begin
            checks++;
            if (gnt_id !== i) begin
                errors++;
                $display("[TB] FAIL %s gnt_id: got %0d expected %0d", name, gnt_id, i);
            end
        end
    endtask

    initial begin
        logic [IDW-1:0] rrSeq[9];
        rrSeq = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd8};

        // Fixed priority: highest set bit wins, done releases.
        addVec(16'h2AF8, 1'b0, 1'b0, 1'b1, 4'd13, 1'b0);
        addVec(16'h01FE, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0);
        addVec(16'h01FE, 1'b0, 1'b0, 1'b1, 4'd8,  1'b0);
        addVec(16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0);
        addVec(16'h0000, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0);
        // Round-robin from reset pointer (fixed grants left it at 15).
        for (int k = 0; k < 9; k++) begin
            addVec(16'h01FE, 1'b1, 1'b0, 1'b1, rrSeq[k], 1'b0);
            addVec(16'h01FE, 1'b1, 1'b1, 1'b0, 4'd0,     1'b0);
        end
        // Hold expiry: four grant cycles then a timeout pulse.
        for (int k = 0; k < 4; k++) addVec(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        addVec(16'h0001, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        addVec(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        // done on the fourth grant cycle beats the timeout.
        for (int k = 0; k < 4; k++) addVec(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        addVec(16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        addVec(16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        // Mode toggled mid-grant, then RR from pointer 7; granted bit dropped.
        addVec(16'h0001, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        addVec(16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
        addVec(16'hFFFF, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        addVec(16'hFFFF, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        addVec(16'h0000, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        addVec(16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        rst_n = 1'b0;
        req   = '0;
        mode  = 1'b0;
        done  = 1'b0;
        #12;
        checkOutput("reset", 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].req, vecs[k].mode, vecs[k].done);
            checkOutput($sformatf("vec%0d", k), vecs[k].vld, vecs[k].id, vecs[k].to);
        end

        // RR grant from pointer 6, then asynchronous reset between edges.
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        checkOutput("preReset", 1'b1, 4'd6, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 1'b0, 4'd0, 1'b0);
        checks++;
        if (gnt_id !== 4'd0) begin
            errors++;
            $display("[TB] FAIL asyncResetId gnt_id: got %0d expected 0", gnt_id);
        end
        @(posedge clk);
        #1;
        req   = '0;
        rst_n = 1'b1;

        // Twenty idle cycles across both modes.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(16'h0000, (k >= 10), 1'b0);
            checkOutput($sformatf("idle%0d", k), 1'b0, 4'd0, 1'b0);
        end

        // Pointer back at 15 after reset; then wrap from a grant of 0.
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        checkOutput("rrAfterReset", 1'b1, 4'd15, 1'b0);
        applyStimulus(16'hFFFF, 1'b1, 1'b1);
        checkOutput("rrRelease1", 1'b0, 4'd0, 1'b0);
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        checkOutput("rrNext14", 1'b1, 4'd14, 1'b0);
        applyStimulus(16'hFFFF, 1'b1, 1'b1);
        checkOutput("rrRelease2", 1'b0, 4'd0, 1'b0);
        applyStimulus(16'h0001, 1'b1, 1'b0);
        checkOutput("rrGrant0", 1'b1, 4'd0, 1'b0);
        applyStimulus(16'h0001, 1'b1, 1'b1);
        checkOutput("rrRelease3", 1'b0, 4'd0, 1'b0);
        applyStimulus(16'h8001, 1'b1, 1'b0);
        checkOutput("rrWrap15", 1'b1, 4'd15, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
